or_and_checker: RTL and testbench
=================================

OR_AND_CHECKER -- requirements
Module: or_and_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2: cycles a stable {a,b,c} must be held before d is checked, range 0..15.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of both counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: checking enable.
REQ-006 The block SHALL have ports a, b, c, input, 1 bit each: the stimulus applied to the unit under check.
REQ-007 The block SHALL have port d, input, 1 bit: the unit-under-check response.
REQ-008 The block SHALL have port sample_cnt, output, CNT_W bits: number of compares performed.
REQ-009 The block SHALL have port err_cnt, output, CNT_W bits: number of mismatching compares.
REQ-010 The block SHALL have port fail, output, 1 bit: sticky flag, set by any mismatch.
REQ-011 The block SHALL have port pass, output, 1 bit: high when sample_cnt != 0 and fail == 0.
REQ-012 The block SHALL have port first_err, output, 4 bits: the {a,b,c,d} values of the first mismatching compare.

Function
REQ-013 Each cycle, a, b, c and d SHALL be registered into a_q, b_q, c_q and d_q; the expected value SHALL be exp = (a_q | b_q) & c_q.
REQ-014 The FSM SHALL have three states: IDLE, WAIT and CHECK; the encoding is internal.
REQ-015 In IDLE, if en=1, the FSM SHALL go to WAIT, and on that edge sample_cnt, err_cnt, fail and first_err SHALL clear to 0 and the settle counter SHALL load SETTLE.
REQ-016 In any state, if en=0, the FSM SHALL go to IDLE; counters, fail and first_err SHALL hold their values.
REQ-017 In WAIT or CHECK, if {a_q,b_q,c_q} differs from the previous cycle's registered value, the settle counter SHALL reload SETTLE and the FSM SHALL go to or stay in WAIT; no compare SHALL occur that cycle.
REQ-018 In WAIT with stable inputs, the settle counter SHALL decrement; when it is 0, the FSM SHALL go to CHECK.
REQ-019 If SETTLE=0, the FSM SHALL go from WAIT to CHECK on the first stable cycle.
REQ-020 In CHECK with stable inputs, one compare SHALL be performed every cycle; sample_cnt SHALL increment by 1.
REQ-021 If a compare finds d_q != exp, err_cnt SHALL increment and fail SHALL set.
REQ-022 If the mismatch is the first one since clear, first_err SHALL load {a_q,b_q,c_q,d_q}; later mismatches SHALL NOT change first_err.
REQ-023 Latency: a mismatch driven on a/b/c/d before edge N SHALL be visible on err_cnt and fail after edge N+1, provided the FSM is in CHECK at edge N+1.
REQ-024 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap; with sample_cnt saturated, compares SHALL continue to update err_cnt and fail.
REQ-025 pass SHALL be combinational from registered state only.
REQ-026 An input change in the same cycle as en deassertion SHALL have no effect: en=0 has priority.

Reset
REQ-027 Asserting reset SHALL, at any time and asynchronously, force IDLE, set sample_cnt=0, err_cnt=0, fail=0, first_err=0 and settle counter=0, clear the input registers to 0, and force pass=0.
REQ-028 If reset is asserted mid-WAIT or mid-CHECK, no partial compare SHALL be recorded.
REQ-029 After reset is released, the block SHALL act only on the first rising clk edge that follows.

Verification
REQ-030 Correct DUT: with SETTLE=2, en=1, a toggling every 10 cycles, b every 50 and c every 100, run 3000 cycles, with d=(a|b)&c driven -> err_cnt=0, fail=0, pass=1, sample_cnt>0.
REQ-031 Stale-x DUT: drive d from the previous cycle's a|b ANDed with c -> fail=1 within 2 cycles of the first settled compare after a change, and first_err matches the offending {a,b,c,d}.
REQ-032 Settle masking: with SETTLE=3, glitch d wrong for 3 cycles after each input change -> err_cnt=0; with a glitch of 4 cycles -> err_cnt increments by 1 per change.
REQ-033 Saturation: with CNT_W=4 and a constantly wrong d for 40 cycles -> err_cnt=15, which holds, and sample_cnt=15.
REQ-034 Enable: deassert en mid-run and toggle inputs with d wrong -> counters frozen; reassert en -> counters and fail clear to 0.
REQ-035 Reset: assert reset between clock edges while fail=1 -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/or_and_checker.sv
// Online checker for a unit computing d = (a | b) & c: registers the stimulus and response,
// waits for the stimulus to settle, then compares every stable cycle and logs mismatches.
module or_and_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail,
  output logic             pass,
  output logic [3:0]       first_err
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic             a_q, b_q, c_q, d_q;
  logic [2:0]       prev_q;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_q, fail_d;
  logic [3:0]       ferr_q, ferr_d;

  logic             exp_w;
  logic             changed_w;
  logic [3:0]       settle_dec_w;

  assign exp_w        = (a_q | b_q) & c_q;
  assign changed_w    = ({a_q, b_q, c_q} != prev_q);
  assign settle_dec_w = (settle_q == 4'd0) ? 4'd0 : settle_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sample_d = sample_q;
    err_d    = err_q;
    fail_d   = fail_q;
    ferr_d   = ferr_q;
    // Disable wins over everything else: results freeze until the next enable clears them.
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = WAIT;
          settle_d = SETTLE_L;
          sample_d = '0;
          err_d    = '0;
          fail_d   = 1'b0;
          ferr_d   = 4'd0;
        end
        WAIT: begin
          if (changed_w) begin
            settle_d = SETTLE_L;
          end else begin
            settle_d = settle_dec_w;
            if (settle_dec_w == 4'd0) state_d = CHECK;
          end
        end
        CHECK: begin
          if (changed_w) begin
            state_d  = WAIT;
            settle_d = SETTLE_L;
          end else begin
            if (sample_q != CNT_MAX) sample_d = sample_q + 1'b1;
            if (d_q != exp_w) begin
              if (err_q != CNT_MAX) err_d = err_q + 1'b1;
              fail_d = 1'b1;
              if (!fail_q) ferr_d = {a_q, b_q, c_q, d_q};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      c_q      <= 1'b0;
      d_q      <= 1'b0;
      prev_q   <= 3'd0;
      settle_q <= 4'd0;
      sample_q <= '0;
      err_q    <= '0;
      fail_q   <= 1'b0;
      ferr_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a;
      b_q      <= b;
      c_q      <= c;
      d_q      <= d;
      prev_q   <= {a_q, b_q, c_q};
      settle_q <= settle_d;
      sample_q <= sample_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      ferr_q   <= ferr_d;
    end
  end

  assign sample_cnt = sample_q;
  assign err_cnt    = err_q;
  assign fail       = fail_q;
  assign first_err  = ferr_q;
  assign pass       = (sample_q != '0) && !fail_q;

endmodule

// File: tb/tb_or_and_checker.sv
// Directed bench for or_and_checker: three instances (default, SETTLE=3, CNT_W=4/SETTLE=0)
// sharing clock, reset and stimulus a/b/c, each with its own enable and response.
module tb_or_and_checker;

  logic clk, reset;
  logic a, b, c;
  logic d0, d1, d2;
  logic en0, en1, en2;

  logic [7:0] s0, e0, s1, e1;
  logic [3:0] s2, e2;
  logic       f0, p0, f1, p1, f2, p2;
  logic [3:0] fe0, fe1, fe2;

  int checks = 0;
  int errors = 0;

  assign d0 = (a | b) & c;

  or_and_checker #(.SETTLE(2), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .en(en0), .a(a), .b(b), .c(c), .d(d0),
    .sample_cnt(s0), .err_cnt(e0), .fail(f0), .pass(p0), .first_err(fe0));
  or_and_checker #(.SETTLE(3), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .en(en1), .a(a), .b(b), .c(c), .d(d1),
    .sample_cnt(s1), .err_cnt(e1), .fail(f1), .pass(p1), .first_err(fe1));
  or_and_checker #(.SETTLE(0), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .en(en2), .a(a), .b(b), .c(c), .d(d2),
    .sample_cnt(s2), .err_cnt(e2), .fail(f2), .pass(p2), .first_err(fe2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en0 = 0; en1 = 0; en2 = 0;
    a = 0; b = 0; c = 0; d1 = 0; d2 = 0;
    tick(); tick();
    chk("rst_sample", 32'(s1), 0);
    chk("rst_err", 32'(e1), 0);
    chk("rst_fail", 32'(f1), 0);
    chk("rst_pass", 32'(p1), 0);
    chk("rst_ferr", 32'(fe1), 0);
    reset = 1'b0;
    tick(); tick();

    // Correct DUT over 3000 cycles; sample count saturates at 255.
    en0 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      a = ((i / 10) % 2) != 0;
      b = ((i / 50) % 2) != 0;
      c = ((i / 100) % 2) != 0;
      tick();
    end
    en0 = 1'b0;
    tick();
    chk("good_err", 32'(e0), 0);
    chk("good_fail", 32'(f0), 0);
    chk("good_pass", 32'(p0), 1);
    chk("good_sample", 32'(s0), 255);
    chk("u1_idle_sample", 32'(s1), 0);

    // SETTLE=3: stable 000 input, first compare 4 edges after entering WAIT.
    a = 0; b = 0; c = 0; d1 = 0;
    repeat (3) tick();
    en1 = 1'b1;
    repeat (8) tick();
    chk("settle_sample", 32'(s1), 4);
    chk("settle_err", 32'(e1), 0);
    chk("settle_pass", 32'(p1), 1);

    // One-cycle wrong d: seen one edge after it is registered.
    d1 = 1'b1;
    tick();
    chk("lat_err_n", 32'(e1), 0);
    d1 = 1'b0;
    tick();
    chk("lat_err_n1", 32'(e1), 1);
    chk("lat_fail", 32'(f1), 1);
    chk("lat_ferr", 32'(fe1), 4'b0001);
    chk("lat_pass", 32'(p1), 0);
    chk("lat_sample", 32'(s1), 6);

    // Change to 101 (exp 1) with d wrong in the change cycle plus 3 more: masked.
    a = 1; c = 1; d1 = 0;
    repeat (4) tick();
    d1 = 1;
    repeat (4) tick();
    chk("mask_err", 32'(e1), 1);
    chk("mask_sample", 32'(s1), 10);

    // Change to 001 (exp 0) with d wrong one cycle longer: exactly one new error.
    a = 0; d1 = 1;
    repeat (5) tick();
    d1 = 0;
    repeat (4) tick();
    chk("glitch_err", 32'(e1), 2);
    chk("glitch_sample", 32'(s1), 15);
    chk("glitch_ferr", 32'(fe1), 4'b0001);

    // Disable together with an input change and wrong d: everything frozen.
    en1 = 0; a = 1; d1 = 0;
    for (int i = 0; i < 6; i++) begin
      b = i[0];
      tick();
    end
    chk("frz_sample", 32'(s1), 15);
    chk("frz_err", 32'(e1), 2);
    chk("frz_fail", 32'(f1), 1);
    chk("frz_ferr", 32'(fe1), 4'b0001);
    en1 = 1'b1;
    tick();
    chk("reen_sample", 32'(s1), 0);
    chk("reen_err", 32'(e1), 0);
    chk("reen_fail", 32'(f1), 0);
    chk("reen_ferr", 32'(fe1), 0);
    chk("reen_pass", 32'(p1), 0);
    en1 = 1'b0;

    // CNT_W=4, SETTLE=0: constant wrong d (abc=101 expects 1) saturates both counters.
    a = 1; b = 0; c = 1; d2 = 0;
    repeat (3) tick();
    en2 = 1'b1;
    repeat (40) tick();
    chk("sat_err", 32'(e2), 15);
    chk("sat_sample", 32'(s2), 15);
    chk("sat_fail", 32'(f2), 1);
    chk("sat_ferr", 32'(fe2), 4'b1010);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_fail", 32'(f2), 0);
    chk("arst_err", 32'(e2), 0);
    chk("arst_sample", 32'(s2), 0);
    chk("arst_ferr", 32'(fe2), 0);
    chk("arst_pass0", 32'(p0), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_err", 32'(e2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
